// File: rtl/data_mem_pkg.sv
// data_mem_pkg -- shared types for the data memory controller.
// Holds the access-size encoding, the controller FSM state type, the legal
// READ_LAT range and the per-request response metadata carried down the
// latency pipeline.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // Everything needed at the response end to turn the raw word into ReadData.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       fault;
    size_e      size;
    logic [1:0] offset;
    logic       sign_ext;
  } rsp_meta_t;

  // Half accesses must be 2-byte aligned, words 4-byte aligned; size 3 never
  // reaches the array.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_HALF:    bad = offset[0];
      SIZE_WORD:    bad = (offset != 2'b00);
      SIZE_ILLEGAL: bad = 1'b1;
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// data_mem_lane -- combinational byte-lane logic for data_mem_ctrl.
// Store side: replicates right-aligned store data across the lanes and
// produces the byte enables (all zero for faulting accesses).
// Load side: shifts the selected bytes down to bit 0 and zero/sign extends.
module data_mem_lane
  import data_mem_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [31:0] st_word,
  output logic [3:0]  st_byte_en,
  output logic        st_fault,
  input  size_e       ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_sign_ext,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Store steering: data is placed on every lane it could land in, the
  // byte enables pick the real destination lanes.
  always_comb begin
    st_fault   = is_misaligned(st_size, st_offset);
    st_word    = st_data;
    st_byte_en = 4'b0000;
    case (st_size)
      SIZE_BYTE: begin
        st_word    = {4{st_data[7:0]}};
        st_byte_en = 4'b0001 << st_offset;
      end
      SIZE_HALF: begin
        st_word    = {2{st_data[15:0]}};
        st_byte_en = st_offset[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: st_byte_en = 4'b1111;
      default:   st_byte_en = 4'b0000;
    endcase
    if (st_fault) begin
      st_byte_en = 4'b0000;
    end
  end

  // Load extraction: little-endian, so the addressed byte moves to bit 0;
  // sign_ext only matters for byte and half loads.
  always_comb begin
    ld_shifted = ld_word >> {ld_offset, 3'b000};
    ld_data    = ld_shifted;
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_sign_ext & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data = {{16{ld_sign_ext & ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl -- pipelined byte-addressable data memory with fixed latency.
// Holds the word array, the INIT/RUN FSM and the READ_LAT-deep response
// pipeline. Build option: define DATA_MEM_CTRL_INIT_EN to clear the array
// word by word after reset; otherwise the FSM enters RUN one edge after
// reset release and the array contents are undefined until written.
// READ_LAT must lie in READ_LAT_MIN..READ_LAT_MAX.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [DEPTH_LOG2+1:0] ReqAddr,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [31:0]           WriteData,
  output logic                  RspValid,
  output logic [31:0]           ReadData,
  output logic                  Fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_e state_q, state_d;
`ifdef DATA_MEM_CTRL_INIT_EN
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = DEPTH_LOG2'(DEPTH - 1);
  logic [DEPTH_LOG2-1:0] init_cnt_q, init_cnt_d;
`endif

  logic                  accept;
  size_e                 req_size;
  logic [31:0]           st_word;
  logic [3:0]            st_byte_en;
  logic                  st_fault;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           word_q [READ_LAT];
  rsp_meta_t             meta_q [READ_LAT];
  rsp_meta_t             meta_d;
  rsp_meta_t             rsp_meta;
  logic [31:0]           ld_data;

  assign req_size = size_e'(ReqSize);
  assign accept   = ReqValid & ReqReady;
  assign rsp_meta = meta_q[READ_LAT-1];

  data_mem_lane u_lane (
    .st_size     (req_size),
    .st_offset   (ReqAddr[1:0]),
    .st_data     (WriteData),
    .st_word     (st_word),
    .st_byte_en  (st_byte_en),
    .st_fault    (st_fault),
    .ld_size     (rsp_meta.size),
    .ld_offset   (rsp_meta.offset),
    .ld_sign_ext (rsp_meta.sign_ext),
    .ld_word     (word_q[READ_LAT-1]),
    .ld_data     (ld_data)
  );

  // FSM next state and ReqReady; the clear counter saturates so RUN is
  // never left until the next reset.
  always_comb begin
    state_d  = state_q;
    ReqReady = 1'b0;
`ifdef DATA_MEM_CTRL_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef DATA_MEM_CTRL_INIT_EN
        if (init_cnt_q == LAST_WORD) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN:  ReqReady = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Array port: the clear sequence owns the port during INIT, requests in RUN.
  always_comb begin
    mem_addr  = ReqAddr[DEPTH_LOG2+1:2];
    mem_wdata = st_word;
    mem_be    = (accept && ReqWrite) ? st_byte_en : 4'b0000;
`ifdef DATA_MEM_CTRL_INIT_EN
    if (state_q == ST_INIT) begin
      mem_addr  = init_cnt_q;
      mem_wdata = '0;
      mem_be    = 4'b1111;
    end
`endif
  end

  // Metadata for the response that an accepted request will produce.
  always_comb begin
    meta_d = '0;
    if (accept) begin
      meta_d.valid    = 1'b1;
      meta_d.write    = ReqWrite;
      meta_d.fault    = st_fault;
      meta_d.size     = req_size;
      meta_d.offset   = ReqAddr[1:0];
      meta_d.sign_ext = ReqSigned;
    end
  end

  // Block RAM with per-lane writes and a registered read; the read word then
  // rides a plain delay line (no reset, data only) alongside its metadata.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) begin
        mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
    if (accept) begin
      word_q[0] <= mem[mem_addr];
    end
    for (int s = 1; s < READ_LAT; s++) begin
      word_q[s] <= word_q[s-1];
    end
  end

  // FSM state, clear counter and response-valid pipeline; reset drops every
  // in-flight response.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
`ifdef DATA_MEM_CTRL_INIT_EN
      init_cnt_q <= '0;
`endif
      for (int s = 0; s < READ_LAT; s++) begin
        meta_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
`ifdef DATA_MEM_CTRL_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      meta_q[0] <= meta_d;
      for (int s = 1; s < READ_LAT; s++) begin
        meta_q[s] <= meta_q[s-1];
      end
    end
  end

  assign RspValid = rsp_meta.valid;
  assign Fault    = rsp_meta.valid & rsp_meta.fault;
  assign ReadData = (rsp_meta.valid && !rsp_meta.write && !rsp_meta.fault) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl -- self-checking bench for data_mem_ctrl
// (DEPTH_LOG2=6, READ_LAT=3). A byte-array reference model predicts every
// response; a monitor records every RspValid pulse with its cycle stamp.
module tb_data_mem_ctrl;

  localparam int DL2    = 6;
  localparam int LAT    = 3;
  localparam int NWORDS = 1 << DL2;
  localparam int NBYTES = 4 * NWORDS;
`ifdef DATA_MEM_CTRL_INIT_EN
  localparam int EXP_ZEROS = NWORDS - 1;
`else
  localparam int EXP_ZEROS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_write = 1'b0;
  logic           req_signed = 1'b0;
  logic [DL2+1:0] req_addr = '0;
  logic [1:0]     req_size = '0;
  logic [31:0]    wdata = '0;
  logic           req_ready;
  logic           rsp_valid;
  logic           fault;
  logic [31:0]    rdata;

  data_mem_ctrl #(.DEPTH_LOG2(DL2), .READ_LAT(LAT)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .ReqValid  (req_valid),
    .ReqReady  (req_ready),
    .ReqWrite  (req_write),
    .ReqAddr   (req_addr),
    .ReqSize   (req_size),
    .ReqSigned (req_signed),
    .WriteData (wdata),
    .RspValid  (rsp_valid),
    .ReadData  (rdata),
    .Fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          fault;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          cyc;
    bit          fault;
    logic [31:0] data;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] model_mem [NBYTES];
  bit         known [NBYTES];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  // Monitor: one cycle stamp per falling edge, one record per response pulse.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rsp_valid === 1'b1) begin
      obs_q.push_back('{cyc, fault, rdata});
    end
  end

  // Drive one request for one cycle and predict its response from the byte
  // model; has_exp overrides the prediction with a hand-derived value.
  task automatic req(input bit wr, input int addr, input int size, input bit sgn,
                     input logic [31:0] wd, input bit has_exp, input bit exp_fault,
                     input logic [31:0] exp_data);
    exp_t        e;
    int          nb;
    logic [31:0] val;
    bit          all_known;
    @(negedge clk);
    #1;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr[DL2+1:0];
    req_size   = size[1:0];
    req_signed = sgn;
    wdata      = wd;
    nb         = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    e.due      = cyc + LAT;
    e.fault    = (size == 3) || ((addr % nb) != 0);
    e.data     = 32'h0;
    e.chk      = 1'b1;
    if (!e.fault) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) begin
          model_mem[addr+k] = wd[8*k +: 8];
          known[addr+k]     = 1'b1;
        end
      end else begin
        val       = 32'h0;
        all_known = 1'b1;
        for (int k = 0; k < nb; k++) begin
          val       = val | (32'(model_mem[addr+k]) << (8*k));
          all_known = all_known & known[addr+k];
        end
        if (sgn && nb < 4 && val[8*nb-1]) begin
          val = val | (32'hFFFF_FFFF << (8*nb));
        end
        e.data = val;
        e.chk  = all_known;
      end
    end
    if (has_exp) begin
      e.fault = exp_fault;
      e.data  = exp_data;
      e.chk   = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_addr   = (DL2+2)'($urandom);
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    wdata      = $urandom;
  endtask

  task automatic test_reset();
    int zeros;
    bit got;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rspvalid: got %b want 0", rsp_valid); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    zeros = 0;
    got   = 1'b0;
    for (int i = 0; i < NWORDS + 8 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1'b1;
      else zeros++;
    end
    n_cmp++;
    if (!got || zeros != EXP_ZEROS) begin
      n_err++;
      $display("FAIL ready_rise: ready_seen=%0d low_cycles_after_release=%0d want %0d", got, zeros, EXP_ZEROS);
    end
    $display("reset: ReqReady rose after %0d low cycles following release", zeros);
`ifdef DATA_MEM_CTRL_INIT_EN
    for (int b = 0; b < NBYTES; b++) begin
      model_mem[b] = 8'h00;
      known[b]     = 1'b1;
    end
    req(1'b0, 'h3C, 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    repeat (LAT - 1) @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL init_load_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL init_load_data: got %h want 00000000", rdata); end
    $display("reset: load word 0x3C after clear -> %h", rdata);
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
`endif
  endtask

  task automatic test_directed();
    exp_t e;
    obs_t o;
    // Word store, then byte / signed half loads from it.
    req(1'b1, 'h10, 2, 1'b0, 32'h1122_3344, 1'b1, 1'b0, 32'h0);
    req(1'b0, 'h13, 0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0011);
    req(1'b0, 'h10, 1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_3344);
    // Byte merge into an all-ones word; upper WriteData bits must be ignored.
    req(1'b1, 'h20, 2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    req(1'b1, 'h21, 0, 1'b0, 32'h1234_5680, 1'b1, 1'b0, 32'h0);
    req(1'b0, 'h20, 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_80FF);
    req(1'b0, 'h21, 0, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80);
    req(1'b0, 'h22, 1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_FFFF);
    req(1'b0, 'h20, 2, 1'b1, 32'h0, 1'b1, 1'b0, 32'hFFFF_80FF);
    // Misaligned and illegal accesses fault and leave the array alone.
    req(1'b1, 'h04, 2, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0);
    req(1'b0, 'h05, 1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    req(1'b0, 'h06, 2, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    req(1'b0, 'h04, 3, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    req(1'b1, 'h05, 1, 1'b0, 32'h0000_BEEF, 1'b1, 1'b1, 32'h0);
    req(1'b1, 'h06, 2, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0);
    req(1'b1, 'h04, 3, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0);
    req(1'b0, 'h04, 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5_A5A5);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL directed_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("directed: cyc=%0d fault=%0d data=%h (want cyc=%0d fault=%0d data=%h)", o.cyc, o.fault, o.data, e.due, e.fault, e.data);
      n_cmp++; if (o.cyc != e.due) begin n_err++; $display("FAIL directed_timing: got cycle %0d want %0d", o.cyc, e.due); end
      n_cmp++; if (o.fault != e.fault) begin n_err++; $display("FAIL directed_fault: got %0d want %0d", o.fault, e.fault); end
      if (e.chk) begin
        n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL directed_data: got %h want %h", o.data, e.data); end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    exp_t e;
    obs_t o;
    int   sel;
    int   sz;
    for (int w = 0; w < 16; w++) begin
      req(1'b1, 'h80 + 4*w, 2, 1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        sel = $urandom_range(0, 9);
        sz  = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
        req(($urandom_range(0, 2) == 0), 'h80 + $urandom_range(0, 63), sz,
            1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 32'h0);
      end
    end
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL random_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("random: cyc=%0d fault=%0d data=%h (want cyc=%0d fault=%0d data=%h)", o.cyc, o.fault, o.data, e.due, e.fault, e.data);
      n_cmp++; if (o.cyc != e.due) begin n_err++; $display("FAIL random_timing: got cycle %0d want %0d", o.cyc, e.due); end
      n_cmp++; if (o.fault != e.fault) begin n_err++; $display("FAIL random_fault: got %0d want %0d", o.fault, e.fault); end
      if (e.chk) begin
        n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL random_data: got %h want %h", o.data, e.data); end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    bit   got;
    // Store then load of the same word on consecutive cycles.
    req(1'b1, 'h40, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    req(1'b0, 'h40, 2, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
    idle();
    repeat (LAT + 2) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("b2b: cyc=%0d fault=%0d data=%h (want cyc=%0d fault=%0d data=%h)", o.cyc, o.fault, o.data, e.due, e.fault, e.data);
      n_cmp++; if (o.cyc != e.due) begin n_err++; $display("FAIL b2b_timing: got cycle %0d want %0d", o.cyc, e.due); end
      n_cmp++; if (o.fault != e.fault) begin n_err++; $display("FAIL b2b_fault: got %0d want %0d", o.fault, e.fault); end
      n_cmp++; if (o.data !== e.data) begin n_err++; $display("FAIL b2b_data: got %h want %h", o.data, e.data); end
    end
    exp_q.delete();
    obs_q.delete();
    // Two loads in flight when reset hits: neither may respond.
    req(1'b0, 'h40, 2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    req(1'b0, 'h44, 2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    repeat (LAT + 3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < NWORDS + 8 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1'b1;
    end
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_on_reset: got %0d responses want 0", obs_q.size());
    end
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %0d want 1", got);
    end
    $display("b2b: responses after mid-flight reset = %0d", obs_q.size());
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words (1024 words).
REQ-002 SHALL have parameter READ_LAT, default 1, legal range 1..4, meaning cycles from request acceptance to response.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 ReqValid  input  1  request present.
REQ-007 ReqReady  output  1  block can accept a request this cycle.
REQ-008 ReqWrite  input  1  1 = store, 0 = load.
REQ-009 ReqAddr  input  DEPTH_LOG2+2  byte address.
REQ-010 ReqSize  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 ReqSigned  input  1  sign-extend load data (byte/half only).
REQ-012 WriteData  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-013 RspValid  output  1  one-cycle response pulse.
REQ-014 ReadData  output  32  extended load data; 0 for stores and faults.
REQ-015 Fault  output  1  qualifies RspValid: access was misaligned or illegal.

Function
REQ-016 A request SHALL be accepted on a rising edge where ReqValid and ReqReady are both 1; every accepted request SHALL produce exactly one RspValid pulse, exactly READ_LAT cycles later.
REQ-017 Responses SHALL return in acceptance order; one request per cycle SHALL be sustainable (fully pipelined, no back-pressure on the response side).
REQ-018 Storage SHALL be 2^DEPTH_LOG2 words with four byte lanes; lane i holds byte address offset i (little-endian).
REQ-019 A store SHALL commit at its acceptance edge, writing only the lanes selected by size and ReqAddr[1:0] and leaving the other lanes unchanged.
REQ-020 A load SHALL sample the array at its acceptance edge, so a load accepted on the cycle after a store to the same word returns the new data.
REQ-021 Load data SHALL be shifted to bit 0, then zero-extended, or sign-extended from bit 7/15 when ReqSigned=1; ReqSigned SHALL be ignored for word loads.
REQ-022 Half accesses with ReqAddr[0]=1, word accesses with ReqAddr[1:0]!=0, and ReqSize=3 SHALL NOT touch the array and SHALL respond with Fault=1 and ReadData=0.
REQ-023 The FSM SHALL have states INIT (clear the array, ReqReady=0) and RUN (ReqReady=1).
REQ-024 In INIT, a DEPTH_LOG2-bit counter SHALL write 0 to word n on cycle n; after the last word the FSM SHALL enter RUN, so ReqReady first rises 2^DEPTH_LOG2 cycles after reset release.
REQ-025 The address counter SHALL NOT wrap back into INIT; RUN is held until reset.

Reset
REQ-026 While Reset_n=0: ReqReady=0, RspValid=0, Fault=0, ReadData=0, the response pipeline is emptied, the FSM is in INIT and the counter is 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight responses with no RspValid pulse; array contents are not reset asynchronously.

Configuration
REQ-028 Macro DATA_MEM_CTRL_INIT_EN defined: the INIT clear sequence of REQ-024 SHALL be included.
REQ-029 Macro DATA_MEM_CTRL_INIT_EN undefined: the FSM SHALL go from reset to RUN on the first clock edge after reset release, and array contents SHALL be undefined until written.

Structure
REQ-030 Package data_mem_pkg SHALL hold the size encodings (BYTE/HALF/WORD/ILLEGAL), the FSM state type, and the READ_LAT bounds.
REQ-031 Combinational sub-module data_mem_lane SHALL perform store lane steering and byte-enable generation, load extraction and extension, and misalignment detection; the top level SHALL hold the array, the FSM and the latency pipeline.

Verification
REQ-032 Reset release with INIT_EN defined, DEPTH_LOG2=4 -> ReqReady=0 for 16 cycles then 1; loading word 0x3C returns 0x00000000.
REQ-033 Store word 0x11223344 to address 0x10, then load byte from 0x13 with ReqSigned=0 -> 0x00000011; load half from 0x10 with ReqSigned=1 -> 0x00003344.
REQ-034 Store byte 0x80 to address 0x21 over word 0xFFFFFFFF, then load word from 0x20 -> 0xFFFF80FF; load byte from 0x21 with ReqSigned=1 -> 0xFFFFFF80.
REQ-035 Load half from 0x05, load word from 0x06, and ReqSize=3 -> each gives RspValid with Fault=1 and ReadData=0, and the array is unchanged.
REQ-036 READ_LAT=3, back-to-back store to 0x40 then load from 0x40 -> two responses 3 cycles after each acceptance, in order, load returning the stored data; Reset_n pulsed with 2 loads in flight -> no RspValid for either.
